// File: rtl/issue_scheduler_if.sv
// issue_scheduler_if: decode-to-scheduler queue input, add/mul issue ports, writebacks, scoreboard and occupancy
interface issue_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          in_valid;
  logic          in_ready;
  logic          in_is_mul;
  logic [2:0]    in_rw;
  logic [2:0]    in_ra;
  logic [2:0]    in_rb;
  logic          add_issue_valid;
  logic [2:0]    add_issue_rw;
  logic [2:0]    add_issue_ra;
  logic [2:0]    add_issue_rb;
  logic          mul_ready;
  logic          mul_issue_valid;
  logic [2:0]    mul_issue_rw;
  logic [2:0]    mul_issue_ra;
  logic [2:0]    mul_issue_rb;
  logic          add_wb_valid;
  logic [2:0]    add_wb_rw;
  logic          mul_wb_valid;
  logic [2:0]    mul_wb_rw;
  logic [7:0]    busy;
  logic [CW-1:0] count;
  modport master (
    output in_valid, in_is_mul, in_rw, in_ra, in_rb, mul_ready,
           add_wb_valid, add_wb_rw, mul_wb_valid, mul_wb_rw,
    input  in_ready, add_issue_valid, add_issue_rw, add_issue_ra, add_issue_rb,
           mul_issue_valid, mul_issue_rw, mul_issue_ra, mul_issue_rb, busy, count
  );
  modport slave (
    input  in_valid, in_is_mul, in_rw, in_ra, in_rb, mul_ready,
           add_wb_valid, add_wb_rw, mul_wb_valid, mul_wb_rw,
    output in_ready, add_issue_valid, add_issue_rw, add_issue_ra, add_issue_rb,
           mul_issue_valid, mul_issue_rw, mul_issue_ra, mul_issue_rb, busy, count
  );
endinterface

// File: rtl/issue_scheduler.sv
// issue_scheduler: age-ordered queue issuing oldest eligible add and mul per cycle under a RAW/WAW/WAR scoreboard; ports clk, rst_n (async low), s (queue in, issue out, writebacks, busy, count)
module issue_scheduler #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  issue_scheduler_if.slave s
);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic       m;
    logic [2:0] rw;
    logic [2:0] ra;
    logic [2:0] rb;
  } ent_t;
  ent_t             q_q [DEPTH];
  ent_t             q_d [DEPTH];
  ent_t             t [DEPTH];
  ent_t             u [DEPTH];
  logic [CW-1:0]    count_q, count_d, pos;
  logic [7:0]       busy_q, busy_d;
  logic [DEPTH-1:0] elig, add_sel, mul_sel, sel, rm1, rm2;
  logic [8:0]       add_f, mul_f;
  logic [1:0]       n_iss;
  logic             enq, p1, p2;
  always_comb begin
    elig = '0;
    add_sel = '0;
    mul_sel = '0;
    add_f = '0;
    mul_f = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = (i < int'(count_q)) && !busy_q[q_q[i].rw] && !busy_q[q_q[i].ra] &&
                !busy_q[q_q[i].rb] && (!q_q[i].m || s.mul_ready);
      for (int j = 0; j < i; j++)
        if (q_q[j].rw == q_q[i].ra || q_q[j].rw == q_q[i].rb || q_q[j].rw == q_q[i].rw ||
            q_q[i].rw == q_q[j].ra || q_q[i].rw == q_q[j].rb)
          elig[i] = 1'b0;
      if (elig[i] && !q_q[i].m && add_sel == '0) add_sel[i] = 1'b1;
      if (elig[i] && q_q[i].m && mul_sel == '0) mul_sel[i] = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      add_f = add_f | (add_sel[i] ? q_q[i][8:0] : 9'h0);
      mul_f = mul_f | (mul_sel[i] ? q_q[i][8:0] : 9'h0);
    end
    // remove the lower issued entry first, then the higher one (now one slot lower)
    sel = add_sel | mul_sel;
    rm1 = sel & (-sel);
    rm2 = (sel & ~rm1) >> 1;
    p1 = 1'b0;
    p2 = 1'b0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      p1 = p1 | rm1[k];
      t[k] = p1 ? q_q[k+1] : q_q[k];
    end
    t[DEPTH-1] = q_q[DEPTH-1];
    for (int k = 0; k < DEPTH - 1; k++) begin
      p2 = p2 | rm2[k];
      u[k] = p2 ? t[k+1] : t[k];
    end
    u[DEPTH-1] = t[DEPTH-1];
    n_iss = {1'b0, |add_sel} + {1'b0, |mul_sel};
    enq = s.in_valid && s.in_ready;
    pos = count_q - CW'(n_iss);
    for (int k = 0; k < DEPTH; k++)
      q_d[k] = (enq && CW'(k) == pos) ? {s.in_is_mul, s.in_rw, s.in_ra, s.in_rb} : u[k];
    count_d = pos + CW'(enq);
    // clears first so a same-register issue wins
    busy_d = busy_q;
    if (s.add_wb_valid) busy_d[s.add_wb_rw] = 1'b0;
    if (s.mul_wb_valid) busy_d[s.mul_wb_rw] = 1'b0;
    if (|add_sel) busy_d[add_f[8:6]] = 1'b1;
    if (|mul_sel) busy_d[mul_f[8:6]] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '{default: '0};
      count_q <= '0;
      busy_q <= '0;
    end else begin
      q_q <= q_d;
      count_q <= count_d;
      busy_q <= busy_d;
    end
  end
  assign s.in_ready = count_q < CW'(DEPTH);
  assign s.count = count_q;
  assign s.busy = busy_q;
  assign s.add_issue_valid = |add_sel;
  assign s.add_issue_rw = add_f[8:6];
  assign s.add_issue_ra = add_f[5:3];
  assign s.add_issue_rb = add_f[2:0];
  assign s.mul_issue_valid = |mul_sel;
  assign s.mul_issue_rw = mul_f[8:6];
  assign s.mul_issue_ra = mul_f[5:3];
  assign s.mul_issue_rb = mul_f[2:0];
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed and randomized checking of issue_scheduler against a queue-based reference model
module tb_issue_scheduler;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic       m;
    logic [2:0] rw;
    logic [2:0] ra;
    logic [2:0] rb;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  issue_scheduler_if #(.DEPTH(DEPTH)) bif();
  issue_scheduler #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .s(bif));
  always #5 clk = ~clk;
  ent_t mq[$];
  logic [7:0] mbusy = '0;
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic bit conflict(input ent_t older, input ent_t e);
    return older.rw == e.ra || older.rw == e.rb || older.rw == e.rw ||
           e.rw == older.ra || e.rw == older.rb;
  endfunction
  function automatic bit ok(input int i);
    if (mbusy[mq[i].rw] || mbusy[mq[i].ra] || mbusy[mq[i].rb]) return 0;
    if (mq[i].m && !bif.mul_ready) return 0;
    for (int j = 0; j < i; j++) if (conflict(mq[j], mq[i])) return 0;
    return 1;
  endfunction
  function automatic int pick(input logic m);
    for (int i = 0; i < mq.size(); i++) if (mq[i].m == m && ok(i)) return i;
    return -1;
  endfunction
  function automatic logic [15:0] exp_port(input int idx);
    if (idx < 0) return 16'h0;
    return {7'h0, 1'b1, mq[idx].rw, mq[idx].ra, mq[idx].rb};
  endfunction
  task automatic step();
    int ai, mi;
    bit enq;
    ent_t ne;
    #1;
    ai = pick(1'b0);
    mi = pick(1'b1);
    chk("in_ready", 16'(bif.in_ready), 16'(mq.size() < DEPTH));
    chk("count", 16'(bif.count), 16'(mq.size()));
    chk("busy", 16'(bif.busy), 16'(mbusy));
    chk("add_port", {7'h0, bif.add_issue_valid, bif.add_issue_rw, bif.add_issue_ra, bif.add_issue_rb}, exp_port(ai));
    chk("mul_port", {7'h0, bif.mul_issue_valid, bif.mul_issue_rw, bif.mul_issue_ra, bif.mul_issue_rb}, exp_port(mi));
    @(posedge clk);
    enq = bif.in_valid && mq.size() < DEPTH;
    ne = {bif.in_is_mul, bif.in_rw, bif.in_ra, bif.in_rb};
    if (bif.add_wb_valid) mbusy[bif.add_wb_rw] = 1'b0;
    if (bif.mul_wb_valid) mbusy[bif.mul_wb_rw] = 1'b0;
    if (ai >= 0) mbusy[mq[ai].rw] = 1'b1;
    if (mi >= 0) mbusy[mq[mi].rw] = 1'b1;
    if (ai > mi) begin
      mq.delete(ai);
      if (mi >= 0) mq.delete(mi);
    end else begin
      if (mi >= 0) mq.delete(mi);
      if (ai >= 0) mq.delete(ai);
    end
    if (enq) mq.push_back(ne);
    @(negedge clk);
  endtask
  task automatic clr_in();
    bif.in_valid = 1'b0;
    bif.in_is_mul = 1'b0;
    bif.in_rw = '0;
    bif.in_ra = '0;
    bif.in_rb = '0;
    bif.add_wb_valid = 1'b0;
    bif.add_wb_rw = '0;
    bif.mul_wb_valid = 1'b0;
    bif.mul_wb_rw = '0;
  endtask
  task automatic push(input logic m, input logic [2:0] rw, input logic [2:0] ra, input logic [2:0] rb);
    bif.in_valid = 1'b1;
    bif.in_is_mul = m;
    bif.in_rw = rw;
    bif.in_ra = ra;
    bif.in_rb = rb;
    step();
    bif.in_valid = 1'b0;
  endtask
  task automatic wb(input logic av, input logic [2:0] ar, input logic mv, input logic [2:0] mr);
    bif.add_wb_valid = av;
    bif.add_wb_rw = ar;
    bif.mul_wb_valid = mv;
    bif.mul_wb_rw = mr;
    step();
    clr_in();
  endtask
  initial begin
    clr_in();
    bif.mul_ready = 1'b1;
    #1;
    chk("rst_count", 16'(bif.count), 16'h0);
    chk("rst_busy", 16'(bif.busy), 16'h0);
    chk("rst_valids", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h0);
    chk("rst_fields", {4'h0, bif.add_issue_rw, bif.add_issue_ra, bif.mul_issue_rw, bif.mul_issue_rb}, 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // RAW: add r1=r2+r3 then mul r4=r1*r1
    push(1'b0, 3'd1, 3'd2, 3'd3);
    bif.in_valid = 1'b1; bif.in_is_mul = 1'b1; bif.in_rw = 3'd4; bif.in_ra = 3'd1; bif.in_rb = 3'd1;
    #1 chk("raw_add_issue", 16'(bif.add_issue_valid), 16'h1);
    step();
    clr_in();
    #1 chk("raw_mul_held", 16'(bif.mul_issue_valid), 16'h0);
    chk("raw_busy1", 16'(bif.busy[1]), 16'h1);
    wb(1'b1, 3'd1, 1'b0, 3'd0);
    #1 chk("raw_mul_issue", 16'(bif.mul_issue_valid), 16'h1);
    step();
    wb(1'b0, 3'd0, 1'b1, 3'd4);
    // dual issue, then mul stalled with add bypassing it
    bif.mul_ready = 1'b0;
    push(1'b1, 3'd5, 3'd6, 3'd7);
    push(1'b0, 3'd1, 3'd2, 3'd3);
    bif.mul_ready = 1'b1;
    #1 chk("dual_valids", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h3);
    step();
    #1 chk("dual_count", 16'(bif.count), 16'h0);
    wb(1'b1, 3'd1, 1'b1, 3'd5);
    bif.mul_ready = 1'b0;
    push(1'b1, 3'd5, 3'd6, 3'd7);
    push(1'b0, 3'd1, 3'd2, 3'd3);
    #1 chk("stall_valids", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h2);
    step();
    #1 chk("stall_count", 16'(bif.count), 16'h1);
    bif.mul_ready = 1'b1;
    wb(1'b1, 3'd1, 1'b0, 3'd0);
    wb(1'b0, 3'd0, 1'b1, 3'd5);
    // WAR: add writes r2 while an older mul still reads it
    bif.mul_ready = 1'b0;
    push(1'b1, 3'd1, 3'd2, 3'd3);
    push(1'b0, 3'd2, 3'd4, 3'd4);
    #1 chk("war_blocked", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h0);
    step();
    bif.mul_ready = 1'b1;
    #1 chk("war_mul", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h1);
    step();
    #1 chk("war_add", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h2);
    step();
    wb(1'b1, 3'd2, 1'b1, 3'd1);
    // full queue of dependent muls
    bif.mul_ready = 1'b0;
    repeat (DEPTH) push(1'b1, 3'd1, 3'd1, 3'd1);
    #1 chk("full_ready", 16'(bif.in_ready), 16'h0);
    chk("full_count", 16'(bif.count), 16'(DEPTH));
    push(1'b0, 3'd2, 3'd3, 3'd4);
    #1 chk("full_keep", 16'(bif.count), 16'(DEPTH));
    bif.mul_ready = 1'b1;
    bif.mul_wb_valid = 1'b1;
    bif.mul_wb_rw = 3'd1;
    repeat (2 * DEPTH) step();
    clr_in();
    #1 chk("drain_count", 16'(bif.count), 16'h0);
    // scoreboard set/clear
    push(1'b0, 3'd3, 3'd0, 3'd0);
    push(1'b0, 3'd6, 3'd0, 3'd0);
    step();
    #1 chk("sb_set", 16'(bif.busy), 16'h48);
    wb(1'b1, 3'd0, 1'b0, 3'd0);
    #1 chk("sb_nonbusy", 16'(bif.busy), 16'h48);
    wb(1'b1, 3'd3, 1'b1, 3'd6);
    #1 chk("sb_clear", 16'(bif.busy), 16'h0);
    // async reset with work in flight
    for (int r = 0; r < 4; r++) push(1'b0, 3'(r), 3'd4, 3'd4);
    step();
    bif.mul_ready = 1'b0;
    repeat (3) push(1'b1, 3'd5, 3'd5, 3'd5);
    #1 chk("pre_rst_busy", 16'(bif.busy), 16'h0F);
    chk("pre_rst_count", 16'(bif.count), 16'h3);
    #1 rst_n = 1'b0;
    bif.mul_ready = 1'b1;
    #1 chk("mid_rst_count", 16'(bif.count), 16'h0);
    chk("mid_rst_busy", 16'(bif.busy), 16'h0);
    chk("mid_rst_valids", {14'h0, bif.add_issue_valid, bif.mul_issue_valid}, 16'h0);
    mq.delete();
    mbusy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 16'(bif.in_ready), 16'h1);
    // randomized traffic
    repeat (3000) begin
      bif.in_valid = $urandom_range(0, 2) != 0;
      bif.in_is_mul = 1'($urandom);
      bif.in_rw = 3'($urandom);
      bif.in_ra = 3'($urandom);
      bif.in_rb = 3'($urandom);
      bif.mul_ready = $urandom_range(0, 3) != 0;
      bif.add_wb_valid = 1'($urandom);
      bif.add_wb_rw = 3'($urandom);
      bif.mul_wb_valid = 1'($urandom);
      bif.mul_wb_rw = 3'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dispatch scheduler between the decode stage and the two execution units: one single-cycle add unit and one non-pipelined multiply unit. Decoded instructions (Rw/Ra/Rb, 3-bit register indices into the 8-entry register file, plus an add/mul class bit) are buffered in an age-ordered queue. Each cycle the block issues at most one add and one mul, oldest eligible first. An 8-bit scoreboard tracks pending destination writes to block RAW, WAW and WAR hazards.

## Interface
- DEPTH, 4, queue entries (2..8)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction offered
- in_ready  out  1  queue can accept; `count < DEPTH`
- in_is_mul  in  1  class: 0 = add, 1 = mul
- in_rw / in_ra / in_rb  in  3 each  destination / source A / source B
- add_issue_valid  out  1  add issued this cycle; add unit always accepts
- add_issue_rw / add_issue_ra / add_issue_rb  out  3 each  fields of issued add
- mul_ready  in  1  multiply unit idle
- mul_issue_valid  out  1  mul issued this cycle; only asserted when mul_ready=1
- mul_issue_rw / mul_issue_ra / mul_issue_rb  out  3 each  fields of issued mul
- add_wb_valid / add_wb_rw  in  1 / 3  add writeback completed for register
- mul_wb_valid / mul_wb_rw  in  1 / 3  mul writeback completed for register
- busy  out  8  scoreboard; bit r = write to r pending
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- Queue: compacting shift queue. Entry 0 is oldest. Each entry holds {is_mul, rw, ra, rb}. Slots at index ≥ count are don't-care.
- Enqueue: when in_valid && in_ready, append at index `count − (number issued this cycle)` after compaction.
- Eligibility of entry i (all conditions must hold):
  - busy[ra], busy[rb] and busy[rw] are all 0.
  - No older entry j<i has rw_j ∈ {ra_i, rb_i, rw_i}.
  - No older entry j<i has rw_i ∈ {ra_j, rb_j}.
  - For a mul entry, mul_ready must also be 1.
- Selection: the add port takes the lowest-index eligible add entry; the mul port takes the lowest-index eligible mul entry. Both may fire in the same cycle. The older-entry hazard check guarantees the pair is independent.
- Issue outputs are combinational from the registered queue, busy and mul_ready. The field outputs hold 0 when the corresponding valid is 0.
- On issue, at the clock edge:
  - busy[rw] is set.
  - The entry is removed and younger entries shift down.
- Writeback: *_wb_valid clears busy[*_wb_rw] at the edge.
  - If add and mul writebacks target the same register, both clears apply.
  - Writeback to a register that is not busy is ignored.
  - A same-cycle set (issue) and clear (writeback) on one register cannot occur, because WAW is blocked. If it does occur anyway, set wins.
- No bypass: an instruction waiting on register r becomes eligible the cycle after the writeback of r.
- in_ready depends only on registered count. A full queue does not accept, even when an issue happens that cycle.

## Timing
- Reset (async, rst_n=0): count=0, busy=0, all issue valids 0, all issue fields 0, in_ready=1 once rst_n is released.
- Reset asserted mid-operation: queue contents and scoreboard are discarded immediately. Outputs go to reset values without waiting for a clock edge.
- Enqueue-to-issue latency: an instruction accepted at edge T is issuable in cycle T+1 at the earliest, and never in the same cycle.
- Writeback at edge T → dependent instruction issues in cycle T+1.
- Full queue: in_ready=0 for every cycle in which count==DEPTH.
- Empty queue: both issue valids are 0.
- Simultaneous enqueue + 2 issues: count changes by +1 −2 = −1 in one edge, and the new entry lands at index count−2.
- mul_ready=0: mul entries stall, while younger independent add entries still issue.

## Test plan
- Reset: drive rst_n=0 mid-stream with 3 entries queued and busy=8'h0F → count=0, busy=0, both issue valids 0 immediately. After release, in_ready=1.
- RAW: enqueue add r1=r2+r3, then mul r4=r1*r1, mul_ready=1.
  - Required: add issues in cycle 1 and busy[1]=1; the mul is held.
  - Pulse add_wb r1 at edge 2 → mul issues in cycle 3.
- Dual issue / out-of-order: queue {mul r5=r6*r7, add r1=r2+r3} with mul_ready=1 → both issue in the same cycle, count 2→0.
  - Repeat with mul_ready=0 → only the add issues; the mul remains at entry 0.
- WAR: queue {mul r1=r2*r3 (mul_ready=0), add r2=r4+r4} → the add is blocked because an older entry reads r2. Raising mul_ready issues the mul, then the add issues in the following cycle.
- Full: fill DEPTH=4 dependent entries → in_ready=0 and count=4. Attempt a 5th with in_valid=1 → not accepted and count stays 4.
- Scoreboard: simultaneous add_wb r3 and mul_wb r6, with busy=8'h48 → busy=0 next edge. A writeback to a non-busy r0 leaves busy unchanged.
